i2c_scl_gen: RTL

//  Parametrised successor to the fixed-ratio I2C bus-clock divider. Generates a 4-quarter SCL waveform
//  (low/high/high/low) from clk. Adds a runtime divider, per-quarter strobes for the byte engine,

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/sync_2ff.sv | 35 +++
 rtl/i2c_scl_gen.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg
// Shared definitions for the I2C SCL generator: the 3-bit SCL phase state
// encoding and a helper that maps a phase to its SCL drive level.
// -----------------------------------------------------------------------------
package i2c_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_Q0      = 3'd1,
    ST_STRETCH = 3'd2,
    ST_Q1      = 3'd3,
    ST_Q2      = 3'd4,
    ST_Q3      = 3'd5
  } state_e;

  // SCL is actively pulled low only in the two low quarters; everywhere else it is released.
  function automatic logic scl_level(input state_e st);
    return (st != ST_Q0) && (st != ST_Q3);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a single asynchronous level.
// Ports:
//   clk    in  system clock
//   rst_n  in  async active-low reset (both flops load RST_VAL)
//   d_i    in  asynchronous input
//   q_o    out synchronised output, 2-cycle latency
// -----------------------------------------------------------------------------
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/i2c_scl_gen.sv
// -----------------------------------------------------------------------------
// i2c_scl_gen
// Generates the I2C SCL waveform as four quarters (low / high / high / low)
// with a runtime quarter length, per-quarter strobes for the byte engine,
// slave clock stretching and a graceful stop when en is withdrawn.
//
// Ports:
//   clk            in   system clock
//   reset          in   async active-low reset
//   en             in   run request (sampled in IDLE and at end of each period)
//   i_div          in   clk cycles per quarter, 0 selects DIV_DEFAULT
//   i_scl_in       in   SCL pad input (async), used for stretch detection
//   o_scl          out  SCL drive level (1 = released)
//   o_tick_change  out  end of Q0: SDA may change
//   o_tick_rise    out  SCL seen high after release; first cycle of Q1
//   o_tick_sample  out  end of Q1: sample SDA
//   o_tick_fall    out  end of Q2: SCL driven low next
//   o_tick_period  out  end of Q3: bit period done
//   o_busy         out  high from IDLE exit until IDLE re-entry
//   o_stretching   out  high while waiting for SCL to rise
//   o_timeout      out  stretch-timeout pulse
//
// Optional feature macro: I2C_SCL_STRETCH_TIMEOUT_EN
//   Defined: a 32-bit stretch counter aborts a stretch lasting TIMEOUT_CYC
//   cycles, pulses o_timeout and returns to IDLE.
//   Undefined: stretching waits indefinitely and o_timeout is tied low.
// -----------------------------------------------------------------------------
module i2c_scl_gen #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 250
`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [DIV_W-1:0] i_div,
  input  logic             i_scl_in,
  output logic             o_scl,
  output logic             o_tick_change,
  output logic             o_tick_rise,
  output logic             o_tick_sample,
  output logic             o_tick_fall,
  output logic             o_tick_period,
  output logic             o_busy,
  output logic             o_stretching,
  output logic             o_timeout
);

  import i2c_pkg::*;

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = DIV_W'(1);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_sel;
  logic             scl_q;
  logic             busy_q;
  logic             scl_s;
  logic             quarter_end;
  logic             str_expired;
  logic             tick_change, tick_rise, tick_sample, tick_fall, tick_period;
  logic             stretching, timeout;

  sync_2ff #(.RST_VAL(1'b1)) u_scl_sync (
    .clk   (clk),
    .rst_n (reset),
    .d_i   (i_scl_in),
    .q_o   (scl_s)
  );

  assign div_sel     = (i_div == CNT_ZERO) ? DIV_W'(DIV_DEFAULT) : i_div;
  assign quarter_end = (cnt_q == (div_q - CNT_ONE));

`ifdef I2C_SCL_STRETCH_TIMEOUT_EN
  logic [31:0] str_cnt_q, str_cnt_d;

  // Stretch counter is zero outside STRETCH, so it restarts on every entry.
  always_comb begin
    if (state_q == ST_STRETCH) begin
      str_cnt_d = str_cnt_q + 32'd1;
    end else begin
      str_cnt_d = 32'd0;
    end
  end

  // Stretch counter register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      str_cnt_q <= 32'd0;
    end else begin
      str_cnt_q <= str_cnt_d;
    end
  end

  assign str_expired = (str_cnt_q == 32'(TIMEOUT_CYC - 1));
`else
  assign str_expired = 1'b0;
`endif

  // Phase sequencing, quarter counting and strobe decode.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    tick_change = 1'b0;
    tick_rise   = 1'b0;
    tick_sample = 1'b0;
    tick_fall   = 1'b0;
    tick_period = 1'b0;
    stretching  = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (en) begin
          state_d = ST_Q0;
          div_d   = div_sel;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_Q0: begin
        if (quarter_end) begin
          tick_change = 1'b1;
          state_d     = ST_STRETCH;
          cnt_d       = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_STRETCH: begin
        cnt_d = CNT_ZERO;
        if (scl_s) begin
          // The cycle SCL is first seen high is already cycle 0 of Q1.
          tick_rise = 1'b1;
          state_d   = ST_Q1;
          cnt_d     = (div_q > CNT_ONE) ? CNT_ONE : CNT_ZERO;
        end else if (str_expired) begin
          stretching = 1'b1;
          timeout    = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          stretching = 1'b1;
        end
      end
      ST_Q1: begin
        if (quarter_end) begin
          tick_sample = 1'b1;
          state_d     = ST_Q2;
          cnt_d       = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_Q2: begin
        if (quarter_end) begin
          tick_fall = 1'b1;
          state_d   = ST_Q3;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_Q3: begin
        if (quarter_end) begin
          tick_period = 1'b1;
          cnt_d       = CNT_ZERO;
          if (en) begin
            state_d = ST_Q0;
            div_d   = div_sel;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, divider and pad-level registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= CNT_ZERO;
      div_q   <= CNT_ZERO;
      scl_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      scl_q   <= scl_level(state_d);
      busy_q  <= (state_d != ST_IDLE);
    end
  end

  assign o_scl         = scl_q;
  assign o_busy        = busy_q;
  assign o_tick_change = tick_change;
  assign o_tick_rise   = tick_rise;
  assign o_tick_sample = tick_sample;
  assign o_tick_fall   = tick_fall;
  assign o_tick_period = tick_period;
  assign o_stretching  = stretching;
  assign o_timeout     = timeout;

endmodule
